// File: rtl/cos_pwm_dac.sv
// cos_pwm_dac: walks the cosine ROM one address per PWM frame and emits the latched sample as a PWM bit stream
module cos_pwm_dac #(
    parameter int ADDR_W   = 6,
    parameter int DATA_W   = 5,
    parameter int PRESCALE = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic [DATA_W-1:0] rom_data,
    output logic [ADDR_W-1:0] addr,
    output logic              pwm_out,
    output logic              sample_stb,
    output logic              period_done
);
    localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(PRESCALE - 1);
    logic [PW-1:0]     pre_q, pre_d;
    logic [DATA_W-1:0] pwm_q, pwm_d, duty_q, duty_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              pwm_out_q, pwm_out_d, stb_q, pd_q;
    logic              tick, frame_end;
    always_comb begin
        tick      = pre_q == PRE_MAX;
        frame_end = en && tick && &pwm_q;
        pre_d     = (!en || tick) ? '0 : pre_q + 1'b1;
        pwm_d     = !en ? '0 : pwm_q + DATA_W'(tick);
        duty_d    = frame_end ? rom_data : duty_q;
        addr_d    = addr_q + ADDR_W'(frame_end);
        pwm_out_d = en && (pwm_q < duty_q);
    end
    // the ROM address advances only at frame end, so rom_data has settled long before it is latched
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pre_q     <= '0;
            pwm_q     <= '0;
            duty_q    <= '0;
            addr_q    <= '0;
            pwm_out_q <= 1'b0;
            stb_q     <= 1'b0;
            pd_q      <= 1'b0;
        end else begin
            pre_q     <= pre_d;
            pwm_q     <= pwm_d;
            duty_q    <= duty_d;
            addr_q    <= addr_d;
            pwm_out_q <= pwm_out_d;
            stb_q     <= frame_end;
            pd_q      <= frame_end && &addr_q;
        end
    end
    assign addr        = addr_q;
    assign pwm_out     = pwm_out_q;
    assign sample_stb  = stb_q;
    assign period_done = pd_q;
endmodule

// File: tb/tb_cos_pwm_dac.sv
// tb_cos_pwm_dac: directed vectors plus multi-cycle sequences for the cosine PWM DAC
module tb_cos_pwm_dac;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       en = 1'b0;
    logic [4:0] rom_data = '0;
    logic [5:0] addr;
    logic       pwm_out, sample_stb, period_done;
    logic [4:0] tab [64];
    logic       use_tab = 1'b0;
    logic [4:0] cval = '0;
    int         tests = 0;
    int         fails = 0;

    cos_pwm_dac #(.ADDR_W(6), .DATA_W(5), .PRESCALE(2)) dut (
        .clk(clk), .reset(reset), .en(en), .rom_data(rom_data),
        .addr(addr), .pwm_out(pwm_out), .sample_stb(sample_stb), .period_done(period_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) rom_data <= use_tab ? tab[addr] : cval;

    typedef struct {
        logic [4:0] val;
        int         hi0;
        int         hi1;
    } vec_t;
    vec_t vecs [4];

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run_frame(output int hi, output int nstb, output int npd, output int a0, output int spos);
        hi = 0; nstb = 0; npd = 0; a0 = 0; spos = -1;
        for (int i = 0; i < 64; i++) begin
            step();
            if (i == 0) a0 = int'(addr);
            hi += int'(pwm_out);
            npd += int'(period_done);
            if (sample_stb) begin
                nstb++;
                spos = i;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        en = 1'b0;
        #1;
        chk("reset_addr", int'(addr), 0);
        chk("reset_pwm", int'(pwm_out), 0);
        chk("reset_stb", int'(sample_stb), 0);
        chk("reset_pd", int'(period_done), 0);
        @(negedge clk);
        reset = 1'b0;
        en = 1'b1;
    endtask

    initial begin
        int q [17] = '{31, 31, 31, 30, 30, 29, 28, 27, 26, 25, 24, 23, 21, 20, 19, 17, 16};
        int hi, nstb, npd, a0, spos, a_saved, idle_hi, idle_stb, idle_addr_bad;
        for (int i = 0; i <= 16; i++) tab[i] = 5'(q[i]);
        for (int i = 17; i <= 32; i++) tab[i] = 5'(31 - q[32-i]);
        for (int i = 33; i < 64; i++) tab[i] = tab[64-i];
        vecs[0] = '{5'd0, 0, 0};
        vecs[1] = '{5'd16, 0, 32};
        vecs[2] = '{5'd31, 0, 62};
        vecs[3] = '{5'd1, 0, 2};

        // constant-duty vectors: frame 0 is always dark, frame 1 plays the constant
        foreach (vecs[v]) begin
            use_tab = 1'b0;
            cval = vecs[v].val;
            do_reset();
            run_frame(hi, nstb, npd, a0, spos);
            chk("const_f0_high", hi, vecs[v].hi0);
            chk("const_f0_stbpos", spos, 63);
            chk("const_f0_stbcnt", nstb, 1);
            run_frame(hi, nstb, npd, a0, spos);
            chk("const_f1_high", hi, vecs[v].hi1);
            chk("const_f1_addr", a0, 1);
        end

        // full cosine period: duty in frame k+1 equals table[k], one period_done per 4096 clk
        use_tab = 1'b1;
        do_reset();
        for (int k = 0; k < 65; k++) begin
            run_frame(hi, nstb, npd, a0, spos);
            chk($sformatf("cos_high_f%0d", k), hi, k == 0 ? 0 : 2 * int'(tab[k-1]));
            chk($sformatf("cos_addr_f%0d", k), a0, k % 64);
            chk($sformatf("cos_pd_f%0d", k), npd, k == 63 ? 1 : 0);
        end

        // enable drop for 10 clk in mid-frame
        for (int i = 0; i < 20; i++) step();
        a_saved = int'(addr);
        chk("idle_pre_addr", a_saved, 1);
        chk("idle_pre_pwm", int'(pwm_out), 1);
        en = 1'b0;
        idle_hi = 0; idle_stb = 0; idle_addr_bad = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            idle_hi += int'(pwm_out);
            idle_stb += int'(sample_stb);
            if (int'(addr) != a_saved) idle_addr_bad++;
        end
        chk("idle_pwm_high", idle_hi, 0);
        chk("idle_stb", idle_stb, 0);
        chk("idle_addr_changes", idle_addr_bad, 0);
        en = 1'b1;
        run_frame(hi, nstb, npd, a0, spos);
        chk("restart_high", hi, 2 * int'(tab[0]));
        chk("restart_stbpos", spos, 63);
        chk("restart_addr", a0, a_saved);
        chk("restart_addr_next", int'(addr), a_saved + 1);

        // asynchronous reset mid-frame at addr 37
        do_reset();
        for (int k = 0; k < 37; k++) run_frame(hi, nstb, npd, a0, spos);
        step();
        chk("midrst_pre_addr", int'(addr), 37);
        chk("midrst_pre_pwm", int'(pwm_out), 1);
        reset = 1'b1;
        #1;
        chk("midrst_addr", int'(addr), 0);
        chk("midrst_pwm", int'(pwm_out), 0);
        chk("midrst_stb", int'(sample_stb), 0);
        @(negedge clk);
        reset = 1'b0;
        run_frame(hi, nstb, npd, a0, spos);
        chk("midrst_f0_high", hi, 0);
        chk("midrst_f0_stbpos", spos, 63);
        chk("midrst_f0_addr", a0, 0);
        run_frame(hi, nstb, npd, a0, spos);
        chk("midrst_f1_high", hi, 2 * int'(tab[0]));
        chk("midrst_f1_addr", a0, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
